// File: rtl/seven_segment_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seven_segment_pkg
//  Description : Shared types, off-state constants and the hex-to-segment map
//                used by the static decoder and the multiplexed driver.
//  Revision    : 1.0 - initial release
// ============================================================================
package seven_segment_pkg;

    typedef logic [7:0] seg_t;

    // Active-low outputs: all ones means every segment / digit is dark.
    localparam seg_t       SEG_OFF   = 8'hFF;
    localparam logic [7:0] ANODE_OFF = 8'hFF;

    // Active-low segment pattern, bit order g..a (bit 6 = g, bit 0 = a).
    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seven_segment_mux_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : seven_segment
//  Description : Combinational hex nibble to active-low seven-segment decoder
//                (segments g..a), the same map as the static display path.
//  Revision    : 1.0 - initial release
// ============================================================================
module seven_segment
    import seven_segment_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Pure lookup, no state.
    assign seg = hex_to_seg(hex);

endmodule
`default_nettype wire

// File: rtl/seven_segment_mux.sv
`default_nettype none
// ============================================================================
//  Module      : seven_segment_mux
//  Description : Time-multiplexed common-anode N-digit driver with per-slot
//                ghosting guard, frame-coherent input shadowing, blanking,
//                decimal points and optional leading-zero suppression.
//  Revision    : 1.0 - initial release
// ============================================================================
module seven_segment_mux
    import seven_segment_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_CYCLES = 100000,
    parameter int GUARD_CYCLES = 1000
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    lz_suppress,
    output logic [7:0]              segment,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    frame_start
);

    localparam int CNT_W = $clog2(DIGIT_CYCLES);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_guard    = CNT_W'(GUARD_CYCLES);
    localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(NUM_DIGITS - 1);

    // Reject illegal configurations at elaboration.
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8 || DIGIT_CYCLES < 2 ||
        GUARD_CYCLES < 1 || GUARD_CYCLES > DIGIT_CYCLES - 1) begin : g_param_check
        $error("seven_segment_mux: parameter out of legal range");
    end

    logic [CNT_W-1:0]          r_cnt;
    logic [IDX_W-1:0]          r_idx;
    logic [4*NUM_DIGITS-1:0]   r_data;
    logic [NUM_DIGITS-1:0]     r_dp;
    logic [NUM_DIGITS-1:0]     r_blank;
    logic                      r_lz;

    logic                      w_load;
    logic [3:0]                w_nibble;
    logic                      w_dp;
    logic                      w_blank;
    logic                      w_zero;
    logic                      w_run;
    logic [NUM_DIGITS-1:0]     w_zero_from;
    logic [NUM_DIGITS-1:0]     w_anode_sel;
    logic [6:0]                w_dec;
    logic [7:0]                w_seg_next;
    logic [NUM_DIGITS-1:0]     w_anode_next;

    // Shadow load happens once per frame, at the first cycle of digit 0.
    assign w_load = (r_idx == '0) && (r_cnt == '0);

    // Slot counter and round-robin digit index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (r_cnt == c_cnt_last) begin
            r_cnt <= '0;
            r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Frame-coherent shadow of all display inputs; blanked until first load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data  <= '0;
            r_dp    <= '0;
            r_blank <= '1;
            r_lz    <= 1'b0;
        end else if (w_load) begin
            r_data  <= data;
            r_dp    <= dp_in;
            r_blank <= blank;
            r_lz    <= lz_suppress;
        end
    end

    // w_zero_from[i]: nibble i and every more-significant nibble are zero.
    always_comb begin
        w_zero_from = '0;
        w_run       = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_run          = w_run && (r_data[4*i +: 4] == 4'h0);
            w_zero_from[i] = w_run;
        end
    end

    // Select the current digit's shadow fields and its anode pattern.
    always_comb begin
        w_nibble    = 4'h0;
        w_dp        = 1'b0;
        w_blank     = 1'b1;
        w_zero      = 1'b0;
        w_anode_sel = ANODE_OFF[NUM_DIGITS-1:0];
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nibble       = r_data[4*i +: 4];
                w_dp           = r_dp[i];
                w_blank        = r_blank[i];
                w_zero         = w_zero_from[i];
                w_anode_sel[i] = 1'b0;
            end
        end
    end

    seven_segment u_decoder (
        .hex (w_nibble),
        .seg (w_dec)
    );

    // Next-output decision: dark during guard, otherwise blank/suppress/decode.
    always_comb begin
        w_seg_next   = SEG_OFF;
        w_anode_next = ANODE_OFF[NUM_DIGITS-1:0];
        if (r_cnt >= c_guard) begin
            w_anode_next = w_anode_sel;
            if (w_blank) begin
                w_seg_next = SEG_OFF;
            end else if (r_lz && (r_idx != '0) && w_zero) begin
                w_seg_next = {~w_dp, 7'h7F};
            end else begin
                w_seg_next = {~w_dp, w_dec};
            end
        end
    end

    // Registered pin drivers; frame_start marks the cycle after a load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            segment     <= SEG_OFF;
            anode       <= ANODE_OFF[NUM_DIGITS-1:0];
            frame_start <= 1'b0;
        end else begin
            segment     <= w_seg_next;
            anode       <= w_anode_next;
            frame_start <= w_load;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seven_segment_mux
//  Description : Self-checking bench for seven_segment_mux (4 digits, 8-cycle
//                slots, 2-cycle guard): arithmetic reference model checked
//                every cycle plus hand-computed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_segment_mux;

    localparam int ND = 4;
    localparam int DC = 8;
    localparam int GC = 2;
    localparam int FRAME = ND * DC;

    logic        clk;
    logic        reset;
    logic [15:0] data;
    logic [3:0]  dp_in;
    logic [3:0]  blank;
    logic        lz_suppress;
    logic [7:0]  segment;
    logic [3:0]  anode;
    logic        frame_start;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: n = state cycles since reset release.
    int          n = 0;
    logic [15:0] sh_data  = '0;
    logic [3:0]  sh_dp    = '0;
    logic [3:0]  sh_blank = '1;
    logic        sh_lz    = 1'b0;

    seven_segment_mux #(
        .NUM_DIGITS   (ND),
        .DIGIT_CYCLES (DC),
        .GUARD_CYCLES (GC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .data        (data),
        .dp_in       (dp_in),
        .blank       (blank),
        .lz_suppress (lz_suppress),
        .segment     (segment),
        .anode       (anode),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] h);
        logic [6:0] g;
        case (h)
            4'h0: g = 7'h40; 4'h1: g = 7'h79; 4'h2: g = 7'h24; 4'h3: g = 7'h30;
            4'h4: g = 7'h19; 4'h5: g = 7'h12; 4'h6: g = 7'h02; 4'h7: g = 7'h78;
            4'h8: g = 7'h00; 4'h9: g = 7'h10; 4'hA: g = 7'h08; 4'hB: g = 7'h03;
            4'hC: g = 7'h46; 4'hD: g = 7'h21; 4'hE: g = 7'h06; default: g = 7'h0E;
        endcase
        return g;
    endfunction

    // Per-cycle compare against the model; outputs lag model state by one cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                check("rst_anode", {28'h0, anode}, 32'hF);
                check("rst_segment", {24'h0, segment}, 32'hFF);
                check("rst_frame_start", {31'h0, frame_start}, 32'h0);
                n        = 0;
                sh_data  = '0;
                sh_dp    = '0;
                sh_blank = '1;
                sh_lz    = 1'b0;
            end else begin
                int         slot_pos;
                int         dig;
                logic [3:0] one;
                logic [3:0] e_anode;
                logic [7:0] e_seg;
                logic       e_fs;
                slot_pos = n % DC;
                dig      = (n / DC) % ND;
                one      = 4'b0001;
                e_fs     = (n % FRAME) == 0;
                e_anode  = 4'hF;
                e_seg    = 8'hFF;
                if (slot_pos >= GC) begin
                    e_anode = ~(one << dig);
                    if (sh_blank[dig])
                        e_seg = 8'hFF;
                    else if (sh_lz && dig > 0 && (sh_data >> (4 * dig)) == 16'h0)
                        e_seg = {~sh_dp[dig], 7'h7F};
                    else
                        e_seg = {~sh_dp[dig], glyph(sh_data[4*dig +: 4])};
                end
                check("model_anode", {28'h0, anode}, {28'h0, e_anode});
                check("model_segment", {24'h0, segment}, {24'h0, e_seg});
                check("model_frame_start", {31'h0, frame_start}, {31'h0, e_fs});
                check("anode_at_most_one_low", {31'h0, ($countones(~anode) <= 1)}, 32'h1);
                if ((n % FRAME) == 0) begin
                    sh_data  = data;
                    sh_dp    = dp_in;
                    sh_blank = blank;
                    sh_lz    = lz_suppress;
                end
                n++;
            end
        end
    end

    // Return just after the negedge at which the DUT shows the output of state s.
    task automatic wait_out(input int s);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while (n != s + 1 && k < 500);
        check("wait_out_timeout", n, s + 1);
    endtask

    // Directed stimulus with hand-computed literal expectations.
    initial begin
        data        = 16'h1234;
        dp_in       = 4'b0000;
        blank       = 4'b0000;
        lz_suppress = 1'b0;
        reset       = 1'b0;
        #1 reset    = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("t1_rst_anode", {28'h0, anode}, 32'hF);
        check("t1_rst_segment", {24'h0, segment}, 32'hFF);
        reset = 1'b0;

        // Reset release and first frame.
        wait_out(0);
        check("t1_first_fs", {31'h0, frame_start}, 32'h1);
        check("t1_first_anode", {28'h0, anode}, 32'hF);
        wait_out(2);
        check("t1_d0_anode", {28'h0, anode}, 32'hE);
        check("t1_d0_seg_4", {24'h0, segment}, 32'h99);
        wait_out(9);
        check("t1_guard_d1", {28'h0, anode}, 32'hF);
        wait_out(10);
        check("t1_d1_anode", {28'h0, anode}, 32'hD);
        check("t1_d1_seg_3", {24'h0, segment}, 32'hB0);

        // Full scan.
        wait_out(26);
        check("t2_d3_anode", {28'h0, anode}, 32'h7);
        check("t2_d3_seg_1", {24'h0, segment}, 32'hF9);
        wait_out(32);
        check("t2_fs_32", {31'h0, frame_start}, 32'h1);

        // Mid-frame update while digit 1 is active.
        wait_out(41);
        data = 16'hABCD;
        wait_out(50);
        check("t3_d2_still_2", {24'h0, segment}, 32'hA4);
        wait_out(58);
        check("t3_d3_still_1", {24'h0, segment}, 32'hF9);
        wait_out(64);
        check("t3_fs_64", {31'h0, frame_start}, 32'h1);
        wait_out(66);
        check("t3_d0_D", {24'h0, segment}, 32'hA1);
        wait_out(90);
        check("t3_d3_A", {24'h0, segment}, 32'h88);

        // Leading-zero suppression.
        lz_suppress = 1'b1;
        data        = 16'h0045;
        wait_out(98);
        check("t4_d0_5", {24'h0, segment}, 32'h92);
        wait_out(106);
        check("t4_d1_4", {24'h0, segment}, 32'h99);
        wait_out(114);
        check("t4_d2_supp", {24'h0, segment}, 32'hFF);
        check("t4_d2_anode", {28'h0, anode}, 32'hB);
        wait_out(122);
        check("t4_d3_supp", {24'h0, segment}, 32'hFF);
        data = 16'h0000;
        wait_out(130);
        check("t4_zero_d0", {24'h0, segment}, 32'hC0);
        wait_out(138);
        check("t4_zero_d1", {24'h0, segment}, 32'hFF);

        // Blank and decimal points.
        data        = 16'h1234;
        lz_suppress = 1'b0;
        dp_in       = 4'b0101;
        blank       = 4'b1000;
        wait_out(162);
        check("t5_d0_dp", {24'h0, segment}, 32'h19);
        wait_out(170);
        check("t5_d1_nodp", {24'h0, segment}, 32'hB0);
        wait_out(178);
        check("t5_d2_dp", {24'h0, segment}, 32'h24);
        wait_out(186);
        check("t5_d3_blank", {24'h0, segment}, 32'hFF);
        check("t5_d3_anode", {28'h0, anode}, 32'h7);

        // Asynchronous reset in mid-slot (digit 2, slot position 5).
        wait_out(212);
        check("t6_pre_anode", {28'h0, anode}, 32'hB);
        reset = 1'b1;
        #1;
        check("t6_async_anode", {28'h0, anode}, 32'hF);
        check("t6_async_segment", {24'h0, segment}, 32'hFF);
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        wait_out(0);
        check("t6_restart_fs", {31'h0, frame_start}, 32'h1);
        wait_out(2);
        check("t6_restart_anode", {28'h0, anode}, 32'hE);
        check("t6_restart_seg", {24'h0, segment}, 32'h19);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
